// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register-bus arbiter
package reg_bus_pkg;

    localparam logic BUS_OP_READ  = 1'b0;
    localparam logic BUS_OP_WRITE = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    localparam logic [15:0] CNT_HI = 16'h5;
    localparam logic [15:0] CNT_LO = 16'h6;
    localparam logic [15:0] INVERT = 16'h9;

    typedef struct packed {
        logic                  op;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } bus_cmd_t;

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rtl/reg_bus_arbiter_rr_pick.sv - one-hot round-robin picker scanning upward from ptr with wrap
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] j;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = wrap_idx(ptr, k);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin sharing of the single-command register bus with lock and read routing
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_op,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   bus_cmd_valid,
    output logic                   bus_op,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wr_data,
    input  logic [DATA_W-1:0]      bus_rd_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    lock_state_e     lock_q, lock_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [NREQ-1:0] eligible, gnt;
    logic [PW-1:0]   win;
    logic            any, accept;
    logic            sel_op, sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic            rd1_v, rd2_v;
    logic [PW-1:0]   rd1_id, rd2_id;

    // While locked, the owner is the only requester allowed to win.
    always_comb begin
        eligible = req_valid;
        if (lock_q == LK_HELD) eligible = req_valid & (NREQ'(1) << owner_q);
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign accept    = any & ~rst;
    assign req_ready = rst ? '0 : gnt;
    assign sel_op    = req_op[win];
    assign sel_lock  = req_lock[win];
    assign sel_addr  = req_addr[int'(win)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(win)*DATA_W +: DATA_W];

    always_comb begin
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (sel_lock) begin
                lock_d  = LK_HELD;
                owner_d = win;
            end else begin
                lock_d = LK_OPEN;
                ptr_d  = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q        <= LK_OPEN;
            ptr_q         <= '0;
            owner_q       <= '0;
            bus_cmd_valid <= 1'b0;
            bus_op        <= 1'b0;
            bus_addr      <= '0;
            bus_wr_data   <= '0;
            rd1_v         <= 1'b0;
            rd1_id        <= '0;
            rd2_v         <= 1'b0;
            rd2_id        <= '0;
        end else begin
            lock_q        <= lock_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            bus_cmd_valid <= accept;
            bus_op        <= accept ? sel_op : 1'b0;
            bus_addr      <= accept ? sel_addr : '0;
            bus_wr_data   <= accept ? sel_wdata : '0;
            rd1_v         <= accept && (sel_op == BUS_OP_READ);
            rd1_id        <= win;
            rd2_v         <= rd1_v;
            rd2_id        <= rd1_id;
        end
    end

    // Target registers read data a cycle after the command, so the second stage lines up with it.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rd2_v) begin
            rsp_valid = NREQ'(1) << rd2_id;
            rsp_rdata = bus_rd_data;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed and randomized checks of reg_bus_arbiter against a behavioural model
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0, req_op = '0, req_lock = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_wdata = '0;
    logic [NREQ-1:0]        req_ready, rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata, bus_wr_data;
    logic [DATA_W-1:0]      bus_rd_data = '0;
    logic                   bus_cmd_valid, bus_op;
    logic [ADDR_W-1:0]      bus_addr;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
    );

    // Register target: 16 words, read data registered one cycle after the command.
    logic [DATA_W-1:0] tgt_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (bus_cmd_valid) begin
            if (bus_op == BUS_OP_WRITE) tgt_mem[bus_addr[3:0]] <= bus_wr_data;
            else                        bus_rd_data <= tgt_mem[bus_addr[3:0]];
        end
    end

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                m_ptr = 0;
    int                m_owner = 0;
    bit                m_locked = 1'b0;
    bit                e_v = 1'b0;
    bus_cmd_t          e_cmd = '0;
    logic [DATA_W-1:0] m_mem [16] = '{default: '0};
    rsp_t              rq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 1'b0;
        e_v      = 1'b0;
        e_cmd    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_cmd_valid"}, 32'(bus_cmd_valid), 32'h0);
        check({tag, "_op"}, 32'(bus_op), 32'h0);
        check({tag, "_addr"}, 32'(bus_addr), 32'h0);
        check({tag, "_wdata"}, 32'(bus_wr_data), 32'h0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model, end at next posedge+1.
    task automatic run_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] op,
                             input logic [NREQ-1:0] lk,
                             input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                             input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        int              win;
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic [DATA_W-1:0] exp_rd, a_data;
        logic [ADDR_W-1:0] a_addr;
        rsp_t            r;
        req_valid = v;
        req_op    = op;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        @(negedge clk);
        win = -1;
        if (m_locked) begin
            if (v[m_owner]) win = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("bus_cmd_valid", 32'(bus_cmd_valid), 32'(e_v));
        check("bus_op", 32'(bus_op), 32'(e_cmd.op));
        check("bus_addr", 32'(bus_addr), 32'(e_cmd.addr));
        check("bus_wr_data", 32'(bus_wr_data), 32'(e_cmd.wdata));
        exp_rv = '0;
        exp_rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv[rq[0].id] = 1'b1;
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        if (win >= 0) begin
            a_addr = (win == 0) ? a0 : a1;
            a_data = (win == 0) ? d0 : d1;
            e_v    = 1'b1;
            e_cmd  = '{op: op[win], addr: a_addr, wdata: a_data};
            if (op[win] == BUS_OP_READ) begin
                r.due  = cyc + 2;
                r.id   = win;
                r.data = m_mem[a_addr[3:0]];
                rq.push_back(r);
            end else begin
                m_mem[a_addr[3:0]] = a_data;
            end
            if (lk[win]) begin
                m_locked = 1'b1;
                m_owner  = win;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (win + 1) % NREQ;
            end
        end else begin
            e_v   = 1'b0;
            e_cmd = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        req_valid = 2'b00;
        rst = 1'b0;
        model_reset();

        // Contention from pointer 0
        for (int i = 0; i < 4; i++)
            run_cycle(2'b11, 2'b11, 2'b00, 16'h1, 16'h2, 16'h1111, 16'h2222);
        idle(2);

        // Write then read back through req0
        run_cycle(2'b01, 2'b01, 2'b00, INVERT, 16'h0, 16'h0001, 16'h0);
        run_cycle(2'b01, 2'b00, 2'b00, INVERT, 16'h0, 16'h0, 16'h0);
        idle(3);

        // Preload counter halves, then cross-routed reads
        run_cycle(2'b01, 2'b01, 2'b00, CNT_HI, 16'h0, 16'hABCD, 16'h0);
        run_cycle(2'b10, 2'b10, 2'b00, 16'h0, CNT_LO, 16'h0, 16'h1234);
        run_cycle(2'b11, 2'b00, 2'b00, CNT_LO, CNT_HI, 16'h0, 16'h0);
        run_cycle(2'b10, 2'b00, 2'b00, CNT_LO, CNT_HI, 16'h0, 16'h0);
        idle(3);

        // Locked two-beat read while req1 waits
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h3, 16'h0, 16'h0);
        run_cycle(2'b11, 2'b00, 2'b01, CNT_HI, 16'h3, 16'h0, 16'h0);
        run_cycle(2'b11, 2'b00, 2'b00, CNT_LO, 16'h3, 16'h0, 16'h0);
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h3, 16'h0, 16'h0);
        idle(3);

        // Owner goes idle while locked: req1 stalls
        run_cycle(2'b10, 2'b10, 2'b00, 16'h0, 16'h4, 16'h0, 16'h0044);
        run_cycle(2'b01, 2'b00, 2'b01, CNT_HI, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++)
            run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h4, 16'h0, 16'h0);
        run_cycle(2'b11, 2'b00, 2'b00, CNT_LO, 16'h4, 16'h0, 16'h0);
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h4, 16'h0, 16'h0);
        idle(3);

        // Reset one cycle after a read is accepted, with a lock pending
        run_cycle(2'b01, 2'b00, 2'b01, CNT_HI, 16'h0, 16'h0, 16'h0);
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;
        idle(3);
        run_cycle(2'b11, 2'b00, 2'b00, 16'h7, 16'h8, 16'h0, 16'h0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            run_cycle(2'($urandom), 2'($urandom), {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
                      16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                      16'($urandom), 16'($urandom));
        // Release any lock left by the random phase and drain
        run_cycle(2'b11, 2'b00, 2'b00, 16'h1, 16'h2, 16'h0, 16'h0);
        run_cycle(2'b11, 2'b00, 2'b00, 16'h1, 16'h2, 16'h0, 16'h0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
